// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between fetch (IF) and load/store (D); optional MEM_ARB_PERF_EN counters
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    output logic                if_stall,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                d_stall,
    input  logic                flush,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_valid
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]         perf_if_stall,
    output logic [31:0]         perf_d_stall,
    output logic [31:0]         perf_conflict
`endif
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state, state_nx;
    logic                owner_d;     // 1: data port owns the transaction, 0: fetch
    logic                kill;        // fetch in flight was flushed; drop its completion
    logic                cmd_we;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;
    logic [BE_W-1:0]     cmd_be;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; data wins over fetch, a flushed fetch is not started
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (d_req || (if_req && !flush)) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (mem_valid) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Capture the winning request as the command for this transaction
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_d   <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_be    <= '0;
        end else if (state == IDLE) begin
            if (d_req) begin
                owner_d   <= 1'b1;
                cmd_we    <= d_we;
                cmd_addr  <= d_addr;
                cmd_wdata <= d_wdata;
                cmd_be    <= d_we ? d_be : {BE_W{1'b1}};
            end else if (if_req && !flush) begin
                owner_d   <= 1'b0;
                cmd_we    <= 1'b0;
                cmd_addr  <= if_addr;
                cmd_wdata <= '0;
                cmd_be    <= {BE_W{1'b1}};
            end
        end
    end

    // Remember a flush that hits an outstanding fetch; forget it once back in IDLE
    always_ff @(posedge clk) begin
        if (reset)
            kill <= 1'b0;
        else if (state == DONE)
            kill <= 1'b0;
        else if (flush && !owner_d && (state == ISSUE || state == WAIT))
            kill <= 1'b1;
    end

    // Response data goes to the owner's register and is held until its next completion
    always_ff @(posedge clk) begin
        if (reset) begin
            if_rdata <= '0;
            d_rdata  <= '0;
        end else if (state == WAIT && mem_valid) begin
            if (owner_d) d_rdata  <= mem_rdata;
            else         if_rdata <= mem_rdata;
        end
    end

    // Memory command is only driven during ISSUE so the port reads zero otherwise
    always_comb begin
        mem_en    = (state == ISSUE);
        mem_we    = mem_en && cmd_we;
        mem_addr  = mem_en ? cmd_addr  : '0;
        mem_wdata = mem_en ? cmd_wdata : '0;
        mem_be    = mem_en ? cmd_be    : '0;
        if_ready  = (state == DONE) && !owner_d && !(kill || flush);
        d_ready   = (state == DONE) && owner_d;
        if_stall  = if_req && !if_ready;
        d_stall   = d_req && !d_ready;
    end

`ifdef MEM_ARB_PERF_EN
    // Saturating stall and conflict counters
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_if_stall <= '0;
            perf_d_stall  <= '0;
            perf_conflict <= '0;
        end else begin
            if (if_stall && perf_if_stall != '1) perf_if_stall <= perf_if_stall + 32'd1;
            if (d_stall && perf_d_stall != '1)   perf_d_stall  <= perf_d_stall + 32'd1;
            if (state == IDLE && if_req && d_req && perf_conflict != '1)
                perf_conflict <= perf_conflict + 32'd1;
        end
    end
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates a single-port unified instruction/data memory between the IF stage (fetch) and the MEM stage (load/store).
- One transaction outstanding at a time.
- Produces per-requester ready pulses and stall levels; the hazard/pipeline control logic ORs these into the global stall.
- Accepts the branch flush so an in-flight fetch response is discarded.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width; byte enables are DATA_W/8 bits

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
if_req  in  1  fetch request, level, held until if_ready
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched instruction, valid when if_ready
if_ready  out  1  one-cycle fetch completion pulse
if_stall  out  1  if_req & ~if_ready
d_req  in  1  data request, level, held until d_ready
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_be  in  DATA_W/8  store byte enables
d_rdata  out  DATA_W  load data, valid when d_ready
d_ready  out  1  one-cycle data completion pulse
d_stall  out  1  d_req & ~d_ready
flush  in  1  branch-taken flush, kills the pending or in-flight fetch
mem_en  out  1  one-cycle memory command strobe
mem_we  out  1  write enable, qualified by mem_en
mem_addr  out  ADDR_W  command address
mem_wdata  out  DATA_W  write data
mem_be  out  DATA_W/8  byte enables; all ones for fetch and load
mem_rdata  in  DATA_W  response data
mem_valid  in  1  response strobe, latency >=1 cycle after mem_en, arbitrary

Behaviour:
- Clock is clk; reset is synchronous, active-high.
- Reset: state IDLE, owner=IF, kill=0. All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, mem_be, if_ready, d_ready, if_rdata, d_rdata.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If d_req: owner=D; latch d_we/d_addr/d_wdata/d_be; go to ISSUE. Data has fixed priority over fetch.
  - Else if if_req & ~flush: owner=IF; latch if_addr; go to ISSUE.
  - Else stay in IDLE.
- ISSUE: mem_en=1 for exactly this cycle, with latched command on mem_*; go to WAIT.
- WAIT:
  - On mem_valid: latch mem_rdata into the owner's rdata register; go to DONE.
  - Otherwise hold; no timeout.
- DONE:
  - Owner's ready=1 for exactly this cycle, unless owner=IF and (kill | flush).
  - Go to IDLE. Requests are not sampled in DONE, so a held request is never double-issued.
- Minimum latency: request sampled in IDLE at cycle 0, mem_en at cycle 1, mem_valid at cycle 2, ready at cycle 3.
- Flush:
  - Sets kill when owner=IF and state is ISSUE or WAIT.
  - The transaction still completes to memory, but if_ready is suppressed in DONE.
  - kill clears on entering IDLE.
  - Flush never affects an owner=D transaction.
- mem_valid outside WAIT is ignored.
- Writes complete the same way. mem_valid is the write ack; d_rdata is updated with mem_rdata (don't-care to the pipeline).
- rdata registers hold their value until the next completion for the same owner.
- Simultaneous if_req and d_req in IDLE: D is issued. IF waits, with if_stall=1 throughout.
- Reset mid-transaction: return to IDLE immediately. A later stray mem_valid is ignored.
- Stall outputs are combinational from the request and ready signals.

Optional Feature:
MEM_ARB_PERF_EN.
- Defined: adds outputs perf_if_stall, perf_d_stall and perf_conflict (each 32 bits), all saturating at all-ones and zeroed by reset:
  - perf_if_stall counts cycles with if_stall=1.
  - perf_d_stall counts cycles with d_stall=1.
  - perf_conflict counts IDLE cycles with if_req & d_req.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Lone fetch: if_req=1, if_addr=0x100; memory answers 1 cycle after mem_en with 0x00500093 → mem_en at cycle 1 with mem_addr=0x100, mem_be=0xF; if_ready pulse at cycle 3; if_rdata=0x00500093; if_stall=1 for cycles 0–2.
- Conflict: if_req and d_req (load, 0x2000) both asserted at cycle 0 → load issued first, d_ready at cycle 3. Fetch is issued from IDLE at cycle 4 (mem_en at cycle 5), if_ready at cycle 7. Exactly one mem_en per transaction.
- Store: d_we=1, addr 0x40, wdata 0xDEADBEEF, be 0x3; memory latency 3 → mem_we=1 with mem_be=0x3 at cycle 1; d_ready at cycle 5; no if_ready.
- Flush in flight: fetch issued, flush pulsed during WAIT; memory later returns data → no if_ready pulse. Next IDLE cycle with if_req re-fetches the new address.
- Reset during WAIT: reset at cycle 2, mem_valid at cycle 4 → state IDLE from cycle 3; no ready pulse; all mem_* outputs 0 until a new request.
- With MEM_ARB_PERF_EN: run the conflict scenario → perf_conflict=1, perf_d_stall=3, perf_if_stall=7.
